cursor_turn_fsm: RTL and testbench
==================================

# cursor_turn_fsm

Parametrised game-flow controller for the board game front end. It owns the cursor position and whose turn it is, and turns held direction keys into auto-repeating cursor moves. It sequences detect, place and turn-change handshakes with the move-legality and disk-placement datapaths. It also detects game end, from the `win` flag or from consecutive passes. It sits between the debounced key inputs and the VGA/board datapath, and generalises the fixed 2-player, 8×8 controller to any board size and player count.

## Interface
- `BOARD_W`, 8, board columns (≥2)
- `BOARD_H`, 8, board rows (≥2)
- `NUM_PLAYERS`, 2, players in rotation (2..8)
- `WRAP`, 1, 1 = cursor wraps at edges; 0 = cursor clamps at edges
- `REPEAT_DELAY`, 25_000_000, held-key cycles before first auto-repeat (≥1)
- `REPEAT_PERIOD`, 5_000_000, cycles between subsequent auto-repeats (≥1)
- `clk`  in  1  system clock; single clock domain
- `restart`  in  1  synchronous, active-high reset
- `go`  in  1  start game from IDLE or END
- `move_up`, `move_down`, `move_left`, `move_right`  in  1 each  level, debounced direction keys
- `place`  in  1  level; request placement at cursor
- `jump`  in  1  level; pass turn
- `detect_done`  in  1  legality result valid (one-cycle pulse)
- `confirm`  in  1  move legal; sampled only with `detect_done`
- `place_done`  in  1  placement datapath finished (one-cycle pulse)
- `win`  in  1  board reports end condition; sampled in CHECK
- `cursor_x`  out  $clog2(BOARD_W)  cursor column
- `cursor_y`  out  $clog2(BOARD_H)  cursor row
- `player`  out  $clog2(NUM_PLAYERS) (min 1)  current player
- `draw_cell`, `plot_empty`, `detect`, `place_disk`, `turn_side`, `illegal`, `game_over`  out  1 each  control strobes/levels
- `state`  out  4  current state code (debug)

## Operation
- States: IDLE, SELECT, ERASE, DRAW, DETECT, DET_WAIT, PLACE, PLACE_WAIT, CHECK, TURN, END.
- IDLE: waits for `go`, then goes to SELECT.
- SELECT: `draw_cell`=1. Event priority is jump > place > move.
  - Move priority: up > down > left > right. Simultaneous directions yield a single move.
- Key events:
  - `place` and `jump` act on their rising edge only.
  - A direction key produces one event on its rising edge.
  - If the key is still held after `REPEAT_DELAY` cycles, further events follow every `REPEAT_PERIOD` cycles.
  - Releasing the key clears its repeat counter.
  - An event that arrives outside SELECT is dropped, not queued.
- Move sequence: SELECT → ERASE → DRAW → SELECT.
  - ERASE asserts `plot_empty` at the old position.
  - The cursor updates on the exit edge of ERASE.
  - DRAW asserts `draw_cell` at the new position.
- Edge behaviour, up at y=0:
  - WRAP=1: y becomes BOARD_H-1.
  - WRAP=0: y stays 0, and the ERASE/DRAW cycle still runs.
  - Left/right at the x edges behave the same way.
- Place: SELECT → DETECT (`detect` pulse) → DET_WAIT until `detect_done`.
  - `confirm`=1: go to PLACE (`place_disk` pulse) → PLACE_WAIT until `place_done` → CHECK.
  - `confirm`=0: pulse `illegal` for one cycle and return to SELECT. The player does not change.
- CHECK: `win`=1 goes to END; otherwise TURN.
- Pass: SELECT on `jump` goes to TURN and increments the pass counter. A completed placement clears the pass counter.
- TURN: pulse `turn_side`. `player` = (`player`+1) mod NUM_PLAYERS. Then SELECT, or END if the pass count equals NUM_PLAYERS.
- END: `game_over`=1. On `go`, return to IDLE, which resets the cursor, player and pass count.

## Timing
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Reset values:
  - state = IDLE.
  - cursor = (0,0), player = 0, pass count = 0.
  - All strobes = 0, `game_over` = 0.
- `restart` wins over every other input on the same edge. Mid-operation it aborts any handshake; late `detect_done`/`place_done` pulses are then ignored in IDLE.
- Move latency: key edge at cycle t (in SELECT).
  - ERASE at t+1.
  - New cursor visible at t+2, together with DRAW.
  - SELECT at t+3.
- Place latency: `detect` is asserted one cycle after the `place` edge. `place_disk` is asserted one cycle after `detect_done`&`confirm`.
- `detect_done` and `place_done` may arrive in the cycle right after the request. The wait states hold indefinitely; there is no timeout.
- Repeat counters are $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) bits wide and count down to 0.

## Structure
- Package `game_pkg`:
  - state enum, with the codes above fixed at 0..10.
  - direction encoding.
  - helper function for the width rule ($clog2, minimum 1).
- Sub-module `key_repeat`, instantiated 4× (one per direction):
  - Parameters: `REPEAT_DELAY`, `REPEAT_PERIOD`. Ports: `clk`, `restart`, `key`, output `evt`.
  - Function: edge detection plus auto-repeat counter. It is the successor of the old rate divider.
- Edge detection for `place` and `jump` is inline in the top module.

## Test plan
- Reset, `go`, one `move_right` pulse → `plot_empty` at (0,0), then `draw_cell` with cursor (1,0); SELECT at t+3.
- WRAP=1, BOARD_W=8, `move_left` at x=0 → x=7. WRAP=0, same stimulus → x stays 0 and the ERASE/DRAW pair still fires.
- REPEAT_DELAY=10, REPEAT_PERIOD=4, `move_down` held 30 cycles → events at 0, 10, 14, 18, 22, 26 ⇒ y=6 (no wrap, BOARD_H=8).
- `place`, `detect_done`=1 with `confirm`=0 → `illegal` pulse, player unchanged. Repeat with `confirm`=1, `place_done`, `win`=0 → `place_disk` then `turn_side`, player 0→1.
- NUM_PLAYERS=3, three consecutive `jump` presses → player 0→1→2→0, then END with `game_over`=1. A placement between passes resets the count.
- `restart` asserted while in DET_WAIT → state IDLE next cycle, cursor (0,0). A subsequent `detect_done` causes no strobe.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the board-game flow controller: state codes,
// cursor directions and the width helper used for parameter-sized ports.
package game_pkg;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SELECT     = 4'd1;
    localparam logic [3:0] S_ERASE      = 4'd2;
    localparam logic [3:0] S_DRAW       = 4'd3;
    localparam logic [3:0] S_DETECT     = 4'd4;
    localparam logic [3:0] S_DET_WAIT   = 4'd5;
    localparam logic [3:0] S_PLACE      = 4'd6;
    localparam logic [3:0] S_PLACE_WAIT = 4'd7;
    localparam logic [3:0] S_CHECK      = 4'd8;
    localparam logic [3:0] S_TURN       = 4'd9;
    localparam logic [3:0] S_END        = 4'd10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // $clog2 with a floor of one bit so single-value ranges still get a wire.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Held-key auto-repeat: one event on the press edge, then one after
// REPEAT_DELAY cycles and every REPEAT_PERIOD cycles while still held.
module key_repeat
    import game_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic restart,
    input  logic key,
    output logic evt
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = width_of(CNT_MAX + 1);

    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    logic          key_q;
    logic [CW-1:0] cnt;

    // The counter reloads one short so that terminal count lands exactly
    // REPEAT_DELAY / REPEAT_PERIOD cycles after the previous event.
    assign evt = key & (~key_q | (cnt == '0));

    always_ff @(posedge clk) begin
        if (restart) begin
            key_q <= 1'b0;
            cnt   <= '0;
        end else begin
            key_q <= key;
            if (!key)
                cnt <= '0;
            else if (!key_q)
                cnt <= DELAY_LOAD;
            else if (cnt == '0)
                cnt <= PERIOD_LOAD;
            else
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/cursor_turn_fsm.sv
// Game-flow controller: cursor movement with auto-repeat, place/detect
// handshakes, player rotation and end-of-game detection.
//
// state      | meaning
// IDLE       | waiting for go; cursor/player/passes at start values
// SELECT     | cursor shown, waiting for jump/place/move event
// ERASE      | blank old cell; cursor steps on exit
// DRAW       | draw cursor at new cell
// DETECT     | request legality check
// DET_WAIT   | wait for detect_done
// PLACE      | request disk placement
// PLACE_WAIT | wait for place_done
// CHECK      | sample win
// TURN       | advance player; END after a full round of passes
// END        | game over, waiting for go
module cursor_turn_fsm
    import game_pkg::*;
#(
    parameter int BOARD_W       = 8,
    parameter int BOARD_H       = 8,
    parameter int NUM_PLAYERS   = 2,
    parameter int WRAP          = 1,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                               clk,
    input  logic                               restart,
    input  logic                               go,
    input  logic                               move_up,
    input  logic                               move_down,
    input  logic                               move_left,
    input  logic                               move_right,
    input  logic                               place,
    input  logic                               jump,
    input  logic                               detect_done,
    input  logic                               confirm,
    input  logic                               place_done,
    input  logic                               win,
    output logic [width_of(BOARD_W)-1:0]       cursor_x,
    output logic [width_of(BOARD_H)-1:0]       cursor_y,
    output logic [width_of(NUM_PLAYERS)-1:0]   player,
    output logic                               draw_cell,
    output logic                               plot_empty,
    output logic                               detect,
    output logic                               place_disk,
    output logic                               turn_side,
    output logic                               illegal,
    output logic                               game_over,
    output logic [3:0]                         state
);

    localparam int XW = width_of(BOARD_W);
    localparam int YW = width_of(BOARD_H);
    localparam int PW = width_of(NUM_PLAYERS);
    localparam int CW = width_of(NUM_PLAYERS + 1);

    localparam logic [XW-1:0] X_MAX  = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(BOARD_H - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_PLAYERS - 1);
    localparam logic [CW-1:0] P_ALL  = CW'(NUM_PLAYERS);

    logic          up_evt, down_evt, left_evt, right_evt;
    logic          place_q, jump_q;
    logic          place_evt, jump_evt, move_evt;
    dir_e          move_dir, dir;
    logic [CW-1:0] pass_cnt;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_rep_up    (.clk(clk), .restart(restart), .key(move_up),    .evt(up_evt));
    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_rep_down  (.clk(clk), .restart(restart), .key(move_down),  .evt(down_evt));
    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_rep_left  (.clk(clk), .restart(restart), .key(move_left),  .evt(left_evt));
    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_rep_right (.clk(clk), .restart(restart), .key(move_right), .evt(right_evt));

    assign place_evt = place & ~place_q;
    assign jump_evt  = jump & ~jump_q;
    assign move_evt  = up_evt | down_evt | left_evt | right_evt;

    always_comb begin
        move_dir = DIR_RIGHT;
        if (up_evt)
            move_dir = DIR_UP;
        else if (down_evt)
            move_dir = DIR_DOWN;
        else if (left_evt)
            move_dir = DIR_LEFT;
    end

    // At an edge the cursor either wraps or stays; the erase/draw pair runs regardless.
    always_comb begin
        next_x = cursor_x;
        next_y = cursor_y;
        case (dir)
            DIR_UP:    next_y = (cursor_y == '0)   ? ((WRAP != 0) ? Y_MAX : '0) : cursor_y - YW'(1);
            DIR_DOWN:  next_y = (cursor_y == Y_MAX) ? ((WRAP != 0) ? '0 : Y_MAX) : cursor_y + YW'(1);
            DIR_LEFT:  next_x = (cursor_x == '0)   ? ((WRAP != 0) ? X_MAX : '0) : cursor_x - XW'(1);
            DIR_RIGHT: next_x = (cursor_x == X_MAX) ? ((WRAP != 0) ? '0 : X_MAX) : cursor_x + XW'(1);
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state    <= S_IDLE;
            cursor_x <= '0;
            cursor_y <= '0;
            player   <= '0;
            pass_cnt <= '0;
            dir      <= DIR_UP;
            illegal  <= 1'b0;
            place_q  <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            place_q <= place;
            jump_q  <= jump;
            illegal <= 1'b0;
            case (state)
                S_IDLE:
                    if (go) state <= S_SELECT;
                S_SELECT:
                    if (jump_evt) begin
                        pass_cnt <= pass_cnt + CW'(1);
                        state    <= S_TURN;
                    end else if (place_evt) begin
                        state <= S_DETECT;
                    end else if (move_evt) begin
                        dir   <= move_dir;
                        state <= S_ERASE;
                    end
                S_ERASE: begin
                    cursor_x <= next_x;
                    cursor_y <= next_y;
                    state    <= S_DRAW;
                end
                S_DRAW:
                    state <= S_SELECT;
                S_DETECT:
                    state <= S_DET_WAIT;
                S_DET_WAIT:
                    if (detect_done) begin
                        if (confirm) begin
                            state <= S_PLACE;
                        end else begin
                            illegal <= 1'b1;
                            state   <= S_SELECT;
                        end
                    end
                S_PLACE:
                    state <= S_PLACE_WAIT;
                S_PLACE_WAIT:
                    if (place_done) begin
                        pass_cnt <= '0;
                        state    <= S_CHECK;
                    end
                S_CHECK:
                    state <= win ? S_END : S_TURN;
                S_TURN: begin
                    player <= (player == P_LAST) ? '0 : player + PW'(1);
                    state  <= (pass_cnt == P_ALL) ? S_END : S_SELECT;
                end
                S_END:
                    if (go) begin
                        cursor_x <= '0;
                        cursor_y <= '0;
                        player   <= '0;
                        pass_cnt <= '0;
                        state    <= S_IDLE;
                    end
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    assign draw_cell  = (state == S_SELECT) || (state == S_DRAW);
    assign plot_empty = (state == S_ERASE);
    assign detect     = (state == S_DETECT);
    assign place_disk = (state == S_PLACE);
    assign turn_side  = (state == S_TURN);
    assign game_over  = (state == S_END);

endmodule

// File: tb/tb_cursor_turn_fsm.sv
// Directed bench: vector table for the main flow on a wrapping 2-player
// instance, hand sequences for repeat, clamp, pass and restart cases.
module tb_cursor_turn_fsm;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_SEL = 4'd1, ST_ERASE = 4'd2, ST_DRAW = 4'd3,
                           ST_DET = 4'd4, ST_DWAIT = 4'd5, ST_PLACE = 4'd6, ST_PWAIT = 4'd7,
                           ST_CHECK = 4'd8, ST_TURN = 4'd9, ST_END = 4'd10;

    localparam logic [10:0] NONE = 11'h000, GO = 11'h400, UP = 11'h200, DN = 11'h100,
                            LF = 11'h080, RT = 11'h040, PL = 11'h020, JP = 11'h010,
                            DD = 11'h008, CF = 11'h004, PD = 11'h002, WN = 11'h001;

    localparam logic [6:0] S0 = 7'h00, CELL = 7'h40, PE = 7'h20, DETS = 7'h10, PDISK = 7'h08,
                           TURNS = 7'h04, ILL = 7'h02, OVER = 7'h01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic restart, go, move_up, move_down, move_left, move_right;
    logic place, jump, detect_done, confirm, place_done, win;

    logic [2:0] a_x, a_y, b_x, b_y;
    logic [0:0] a_p;
    logic [1:0] b_p;
    logic [3:0] a_state, b_state;
    logic a_draw, a_plot, a_det, a_pdisk, a_turn, a_ill, a_over;
    logic b_draw, b_plot, b_det, b_pdisk, b_turn, b_ill, b_over;
    logic [6:0] a_stb, b_stb;

    assign a_stb = {a_draw, a_plot, a_det, a_pdisk, a_turn, a_ill, a_over};
    assign b_stb = {b_draw, b_plot, b_det, b_pdisk, b_turn, b_ill, b_over};

    cursor_turn_fsm #(.BOARD_W(8), .BOARD_H(8), .NUM_PLAYERS(2), .WRAP(1),
                      .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_a (
        .clk(clk), .restart(restart), .go(go), .move_up(move_up), .move_down(move_down),
        .move_left(move_left), .move_right(move_right), .place(place), .jump(jump),
        .detect_done(detect_done), .confirm(confirm), .place_done(place_done), .win(win),
        .cursor_x(a_x), .cursor_y(a_y), .player(a_p), .draw_cell(a_draw), .plot_empty(a_plot),
        .detect(a_det), .place_disk(a_pdisk), .turn_side(a_turn), .illegal(a_ill),
        .game_over(a_over), .state(a_state));

    cursor_turn_fsm #(.BOARD_W(8), .BOARD_H(8), .NUM_PLAYERS(3), .WRAP(0),
                      .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_b (
        .clk(clk), .restart(restart), .go(go), .move_up(move_up), .move_down(move_down),
        .move_left(move_left), .move_right(move_right), .place(place), .jump(jump),
        .detect_done(detect_done), .confirm(confirm), .place_done(place_done), .win(win),
        .cursor_x(b_x), .cursor_y(b_y), .player(b_p), .draw_cell(b_draw), .plot_empty(b_plot),
        .detect(b_det), .place_disk(b_pdisk), .turn_side(b_turn), .illegal(b_ill),
        .game_over(b_over), .state(b_state));

    typedef struct {
        logic [10:0] in;
        logic [3:0]  st;
        int          x;
        int          y;
        int          p;
        logic [6:0]  stb;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(logic [10:0] in, logic [3:0] st, int x, int y, int p, logic [6:0] stb);
        vec_t v;
        v.in = in; v.st = st; v.x = x; v.y = y; v.p = p; v.stb = stb;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [10:0] v);
        {go, move_up, move_down, move_left, move_right, place, jump,
         detect_done, confirm, place_done, win} = v;
        tick();
    endtask

    task automatic do_restart();
        step(NONE);
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        logic [31:0] ev_mask;
        logic [31:0] ev_exp;
        restart = 1'b1;
        {go, move_up, move_down, move_left, move_right, place, jump,
         detect_done, confirm, place_done, win} = NONE;
        tick();
        tick();
        chk("reset a state", a_state, ST_IDLE);
        chk("reset a x", a_x, 0);
        chk("reset a y", a_y, 0);
        chk("reset a player", a_p, 0);
        chk("reset a strobes", a_stb, S0);
        chk("reset b strobes", b_stb, S0);
        restart = 1'b0;

        tbl.push_back(mk(GO,      ST_SEL,   0, 0, 0, CELL));
        tbl.push_back(mk(RT,      ST_ERASE, 0, 0, 0, PE));
        tbl.push_back(mk(RT,      ST_DRAW,  1, 0, 0, CELL));
        tbl.push_back(mk(NONE,    ST_SEL,   1, 0, 0, CELL));
        tbl.push_back(mk(LF,      ST_ERASE, 1, 0, 0, PE));
        tbl.push_back(mk(NONE,    ST_DRAW,  0, 0, 0, CELL));
        tbl.push_back(mk(NONE,    ST_SEL,   0, 0, 0, CELL));
        tbl.push_back(mk(LF,      ST_ERASE, 0, 0, 0, PE));
        tbl.push_back(mk(NONE,    ST_DRAW,  7, 0, 0, CELL));
        tbl.push_back(mk(NONE,    ST_SEL,   7, 0, 0, CELL));
        tbl.push_back(mk(RT,      ST_ERASE, 7, 0, 0, PE));
        tbl.push_back(mk(NONE,    ST_DRAW,  0, 0, 0, CELL));
        tbl.push_back(mk(NONE,    ST_SEL,   0, 0, 0, CELL));
        tbl.push_back(mk(UP | RT, ST_ERASE, 0, 0, 0, PE));
        tbl.push_back(mk(NONE,    ST_DRAW,  0, 7, 0, CELL));
        tbl.push_back(mk(NONE,    ST_SEL,   0, 7, 0, CELL));
        tbl.push_back(mk(PL,      ST_DET,   0, 7, 0, DETS));
        tbl.push_back(mk(PL,      ST_DWAIT, 0, 7, 0, S0));
        tbl.push_back(mk(DD,      ST_SEL,   0, 7, 0, CELL | ILL));
        tbl.push_back(mk(NONE,    ST_SEL,   0, 7, 0, CELL));
        tbl.push_back(mk(PL,      ST_DET,   0, 7, 0, DETS));
        tbl.push_back(mk(NONE,    ST_DWAIT, 0, 7, 0, S0));
        tbl.push_back(mk(DD | CF, ST_PLACE, 0, 7, 0, PDISK));
        tbl.push_back(mk(NONE,    ST_PWAIT, 0, 7, 0, S0));
        tbl.push_back(mk(PD,      ST_CHECK, 0, 7, 0, S0));
        tbl.push_back(mk(NONE,    ST_TURN,  0, 7, 0, TURNS));
        tbl.push_back(mk(NONE,    ST_SEL,   0, 7, 1, CELL));
        tbl.push_back(mk(JP,      ST_TURN,  0, 7, 1, TURNS));
        tbl.push_back(mk(NONE,    ST_SEL,   0, 7, 0, CELL));
        tbl.push_back(mk(JP,      ST_TURN,  0, 7, 0, TURNS));
        tbl.push_back(mk(NONE,    ST_END,   0, 7, 1, OVER));
        tbl.push_back(mk(GO,      ST_IDLE,  0, 0, 0, S0));
        tbl.push_back(mk(GO,      ST_SEL,   0, 0, 0, CELL));
        tbl.push_back(mk(PL,      ST_DET,   0, 0, 0, DETS));
        tbl.push_back(mk(NONE,    ST_DWAIT, 0, 0, 0, S0));
        tbl.push_back(mk(DD | CF, ST_PLACE, 0, 0, 0, PDISK));
        tbl.push_back(mk(NONE,    ST_PWAIT, 0, 0, 0, S0));
        tbl.push_back(mk(PD,      ST_CHECK, 0, 0, 0, S0));
        tbl.push_back(mk(WN,      ST_END,   0, 0, 0, OVER));
        tbl.push_back(mk(NONE,    ST_END,   0, 0, 0, OVER));

        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d state", i), a_state, tbl[i].st);
            chk($sformatf("vec%0d x", i), a_x, tbl[i].x);
            chk($sformatf("vec%0d y", i), a_y, tbl[i].y);
            chk($sformatf("vec%0d player", i), a_p, tbl[i].p);
            chk($sformatf("vec%0d strobes", i), a_stb, tbl[i].stb);
        end

        // held move_down: events at 0, 10, 14, 18, 22, 26
        do_restart();
        step(GO);
        ev_mask = '0;
        for (int i = 0; i < 30; i++) begin
            step(DN);
            if (a_plot) ev_mask[i] = 1'b1;
        end
        ev_exp = 32'h0444_4401;
        for (int i = 0; i < 4; i++) step(NONE);
        chk("repeat event cycles", ev_mask, ev_exp);
        chk("repeat final y", a_y, 6);
        chk("repeat final state", a_state, ST_SEL);

        // clamp at edges on the non-wrapping instance
        do_restart();
        step(GO);
        step(LF);
        chk("clamp left erase", b_stb, PE);
        step(NONE);
        chk("clamp left draw state", b_state, ST_DRAW);
        chk("clamp left x", b_x, 0);
        step(NONE);
        step(UP);
        chk("clamp up erase", b_state, ST_ERASE);
        step(NONE);
        chk("clamp up y", b_y, 0);
        chk("clamp up draw", b_stb, CELL);

        // three passes with three players end the game
        do_restart();
        step(GO);
        for (int k = 1; k <= 3; k++) begin
            step(JP);
            chk($sformatf("pass%0d turn", k), b_stb, TURNS);
            step(NONE);
            chk($sformatf("pass%0d player", k), b_p, k % 3);
        end
        chk("pass end state", b_state, ST_END);
        chk("pass game_over", b_over, 1);

        // placement between passes clears the count
        do_restart();
        step(GO);
        step(JP); step(NONE);
        step(JP); step(NONE);
        chk("mid player", b_p, 2);
        step(PL); step(NONE); step(DD | CF); step(NONE); step(PD); step(NONE); step(NONE);
        chk("after place player", b_p, 0);
        chk("after place state", b_state, ST_SEL);
        step(JP); step(NONE);
        chk("pass after place state", b_state, ST_SEL);
        chk("pass after place player", b_p, 1);

        // restart inside DET_WAIT, then a late detect_done
        do_restart();
        step(GO);
        step(RT); step(NONE); step(NONE);
        chk("pre-abort x", a_x, 1);
        step(PL); step(NONE);
        chk("pre-abort state", a_state, ST_DWAIT);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("abort state", a_state, ST_IDLE);
        chk("abort x", a_x, 0);
        step(DD | CF);
        chk("late done state", a_state, ST_IDLE);
        chk("late done strobes", a_stb, S0);
        step(NONE);
        chk("late done settle", a_stb, S0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
